// File: rtl/ysyx_23060191_ifu_axi_pkg.sv
// Shared definitions for the multi-cycle AXI4-Lite instruction fetch unit:
// datapath width, FSM state encoding, error codes and the NOP returned on faults.
package ysyx_23060191_ifu_axi_pkg;

  localparam int CPU_WIDTH = 32;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [1:0] {
    IFU_IDLE = 2'd0,
    IFU_ADDR = 2'd1,
    IFU_DATA = 2'd2,
    IFU_OUT  = 2'd3
  } ifu_state_e;

  localparam logic [1:0] IFU_ERR_OK       = 2'd0;
  localparam logic [1:0] IFU_ERR_BUS      = 2'd1;
  localparam logic [1:0] IFU_ERR_MISALIGN = 2'd2;

endpackage

// File: rtl/ysyx_23060191_ifu_axi_if.sv
// PCU request, AXI4-Lite read channels and IDU response bundled for the fetch unit.
// master = the IFU itself, slave = everything around it (PCU, bus, IDU).
interface ysyx_23060191_ifu_axi_if #(
  parameter int CPU_WIDTH = ysyx_23060191_ifu_axi_pkg::CPU_WIDTH
);
  logic                 pc_valid;
  logic [CPU_WIDTH-1:0] pc;
  logic                 pc_ready;
  logic                 flush;
  logic [CPU_WIDTH-1:0] araddr;
  logic                 arvalid;
  logic                 arready;
  logic [CPU_WIDTH-1:0] rdata;
  logic [1:0]           rresp;
  logic                 rvalid;
  logic                 rready;
  logic                 inst_valid;
  logic [CPU_WIDTH-1:0] inst;
  logic [CPU_WIDTH-1:0] inst_pc;
  logic [1:0]           inst_err;
  logic                 inst_ready;

  modport master (
    input  pc_valid, pc, flush, arready, rdata, rresp, rvalid, inst_ready,
    output pc_ready, araddr, arvalid, rready, inst_valid, inst, inst_pc, inst_err
  );

  modport slave (
    output pc_valid, pc, flush, arready, rdata, rresp, rvalid, inst_ready,
    input  pc_ready, araddr, arvalid, rready, inst_valid, inst, inst_pc, inst_err
  );
endinterface

// File: rtl/ysyx_23060191_ifu_axi.sv
// Multi-cycle fetch: one outstanding AXI4-Lite read per PC, result held in a
// one-entry output register until the IDU takes it.
module ysyx_23060191_ifu_axi #(
  parameter int                   CPU_WIDTH = ysyx_23060191_ifu_axi_pkg::CPU_WIDTH,
  parameter logic [CPU_WIDTH-1:0] NOP_INST  = ysyx_23060191_ifu_axi_pkg::NOP_INST
) (
  input  logic                    clk,
  input  logic                    rstn,
  ysyx_23060191_ifu_axi_if.master bus
);
  import ysyx_23060191_ifu_axi_pkg::*;

  ifu_state_e           state_q, state_d;
  logic [CPU_WIDTH-1:0] pc_q, pc_d;
  logic [CPU_WIDTH-1:0] araddr_q, araddr_d;
  logic                 arvalid_q, arvalid_d;
  logic                 rready_q, rready_d;
  logic                 inst_valid_q, inst_valid_d;
  logic [CPU_WIDTH-1:0] inst_q, inst_d;
  logic [CPU_WIDTH-1:0] inst_pc_q, inst_pc_d;
  logic [1:0]           inst_err_q, inst_err_d;
  logic                 drop_q, drop_d;
  logic                 pc_ready;

  assign pc_ready = (state_q == IFU_IDLE) && !bus.flush;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    araddr_d     = araddr_q;
    arvalid_d    = arvalid_q;
    rready_d     = rready_q;
    inst_valid_d = inst_valid_q;
    inst_d       = inst_q;
    inst_pc_d    = inst_pc_q;
    inst_err_d   = inst_err_q;
    drop_d       = drop_q;

    unique case (state_q)
      IFU_IDLE: begin
        if (bus.pc_valid && pc_ready) begin
          pc_d = bus.pc;
          if (bus.pc[1:0] != 2'b00) begin
            state_d      = IFU_OUT;
            inst_valid_d = 1'b1;
            inst_d       = NOP_INST;
            inst_pc_d    = bus.pc;
            inst_err_d   = IFU_ERR_MISALIGN;
          end else begin
            state_d   = IFU_ADDR;
            arvalid_d = 1'b1;
            araddr_d  = bus.pc;
          end
        end
      end
      IFU_ADDR: begin
        // A redirect cannot cancel the AR beat, so remember to discard the response.
        if (bus.flush) drop_d = 1'b1;
        if (bus.arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = IFU_DATA;
        end
      end
      IFU_DATA: begin
        if (bus.rvalid) begin
          rready_d = 1'b0;
          if (drop_q || bus.flush) begin
            drop_d  = 1'b0;
            state_d = IFU_IDLE;
          end else begin
            inst_valid_d = 1'b1;
            inst_pc_d    = pc_q;
            inst_err_d   = (bus.rresp != 2'b00) ? IFU_ERR_BUS : IFU_ERR_OK;
            inst_d       = (bus.rresp != 2'b00) ? NOP_INST : bus.rdata;
            state_d      = IFU_OUT;
          end
        end else if (bus.flush) begin
          drop_d = 1'b1;
        end
      end
      IFU_OUT: begin
        if (bus.inst_ready || bus.flush) begin
          inst_valid_d = 1'b0;
          state_d      = IFU_IDLE;
        end
      end
      default: state_d = IFU_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= IFU_IDLE;
      pc_q         <= '0;
      araddr_q     <= '0;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      inst_valid_q <= 1'b0;
      inst_q       <= '0;
      inst_pc_q    <= '0;
      inst_err_q   <= IFU_ERR_OK;
      drop_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      araddr_q     <= araddr_d;
      arvalid_q    <= arvalid_d;
      rready_q     <= rready_d;
      inst_valid_q <= inst_valid_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
      inst_err_q   <= inst_err_d;
      drop_q       <= drop_d;
    end
  end

  assign bus.pc_ready   = pc_ready;
  assign bus.araddr     = araddr_q;
  assign bus.arvalid    = arvalid_q;
  assign bus.rready     = rready_q;
  assign bus.inst_valid = inst_valid_q;
  assign bus.inst       = inst_q;
  assign bus.inst_pc    = inst_pc_q;
  assign bus.inst_err   = inst_err_q;

endmodule
